parity_mode_counter: RTL

//  Parametrised successor of the synchronous odd/even counter.

---
 rtl/parity_mode_counter_pkg.sv | 15 +
 rtl/parity_mode_counter_limit_decode.sv | 37 +++
 rtl/parity_mode_counter.sv | 89 ++++++++
 3 files changed

// File: rtl/parity_mode_counter_pkg.sv
// Shared mode encodings and helpers for the parity/binary mode counter.
package parity_mode_counter_pkg;

    typedef enum logic [1:0] {
        MODE_EVEN_UP  = 2'b00,
        MODE_ODD_UP   = 2'b01,
        MODE_BIN_UP   = 2'b10,
        MODE_BIN_DOWN = 2'b11
    } mode_e;

    function automatic logic is_parity_mode(mode_e m);
        return (m == MODE_EVEN_UP) || (m == MODE_ODD_UP);
    endfunction

endpackage

// File: rtl/parity_mode_counter_limit_decode.sv
// Maps a counting mode to its start value, terminal value and per-step increment.
module cnt_limit_decode
    import parity_mode_counter_pkg::*;
#(
    parameter int CNT_WIDTH = 4
) (
    input  mode_e                mode,
    output logic [CNT_WIDTH-1:0] start_val,
    output logic [CNT_WIDTH-1:0] term_val,
    output logic [CNT_WIDTH-1:0] step_val
);

    always_comb begin
        start_val = '0;
        term_val  = '1;
        step_val  = CNT_WIDTH'(1);
        unique case (mode)
            MODE_EVEN_UP: begin
                term_val = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
                step_val = CNT_WIDTH'(2);
            end
            MODE_ODD_UP: begin
                start_val = CNT_WIDTH'(1);
                step_val  = CNT_WIDTH'(2);
            end
            MODE_BIN_UP: ;
            MODE_BIN_DOWN: begin
                // all-ones step is -1 modulo 2^CNT_WIDTH
                start_val = '1;
                term_val  = '0;
                step_val  = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/parity_mode_counter.sv
// Four-mode event counter with clear, load, wrap/saturate policy,
// terminal-count decode and sticky overflow.
module parity_mode_counter
    import parity_mode_counter_pkg::*;
#(
    parameter int CNT_WIDTH = 4,
    parameter int WRAP      = 1
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Enable,
    input  logic                 Clear,
    input  logic                 Load,
    input  logic [CNT_WIDTH-1:0] LoadValue,
    input  logic [1:0]           Mode,
    output logic [CNT_WIDTH-1:0] CounterOut,
    output logic                 TermCount,
    output logic                 Overflow
);

    mode_e                mode_in;
    mode_e                mode_d, mode_q;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    logic                 ovf_d, ovf_q;

    logic [CNT_WIDTH-1:0] nxt_start, nxt_term, nxt_step;
    logic [CNT_WIDTH-1:0] reg_start_unused, reg_term, reg_step_unused;
    logic                 unused_ok;

    assign mode_in = mode_e'(Mode);

    // Next-state limits follow the incoming mode; TermCount follows the registered one.
    cnt_limit_decode #(.CNT_WIDTH(CNT_WIDTH)) u_dec_next (
        .mode      (mode_in),
        .start_val (nxt_start),
        .term_val  (nxt_term),
        .step_val  (nxt_step)
    );

    cnt_limit_decode #(.CNT_WIDTH(CNT_WIDTH)) u_dec_reg (
        .mode      (mode_q),
        .start_val (reg_start_unused),
        .term_val  (reg_term),
        .step_val  (reg_step_unused)
    );

    assign unused_ok = ^{reg_start_unused, reg_step_unused};

    always_comb begin
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        mode_d = mode_in;
        if (Clear) begin
            cnt_d = nxt_start;
            ovf_d = 1'b0;
        end else if (mode_in != mode_q) begin
            cnt_d = nxt_start;
        end else if (Load) begin
            cnt_d = LoadValue;
            if (is_parity_mode(mode_in))
                cnt_d[0] = (mode_in == MODE_ODD_UP);
        end else if (Enable) begin
            if (cnt_q == nxt_term) begin
                ovf_d = 1'b1;
                if (WRAP != 0)
                    cnt_d = nxt_start;
            end else begin
                cnt_d = cnt_q + nxt_step;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q  <= '0;
            mode_q <= MODE_EVEN_UP;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            ovf_q  <= ovf_d;
        end
    end

    assign CounterOut = cnt_q;
    assign TermCount  = (cnt_q == reg_term);
    assign Overflow   = ovf_q;

endmodule
